// File: rtl/sirc_key_decoder.sv
// Turns received SIRC frames into clean key events: press/release pulses, a held level and a repeat count.
// Frames may be filtered by device address; a held key is dropped after REPEAT_TIMEOUT idle cycles.
module sirc_key_decoder #(
  parameter logic [4:0] ADDRESS        = 5'd1,
  parameter bit         ADDR_FILTER    = 1'b1,
  parameter int         CONFIRM_FRAMES = 1,
  parameter int         REPEAT_TIMEOUT = 3000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] data,
  input  logic        data_rdy,
  output logic [6:0]  cmd,
  output logic [4:0]  addr,
  output logic        press,
  output logic        held,
  output logic        key_release,  // "release" is a reserved word
  output logic [7:0]  repeat_count
);

  localparam int             TW   = $clog2(REPEAT_TIMEOUT + 1);
  localparam logic [TW-1:0]  TMAX = TW'(REPEAT_TIMEOUT);
  localparam logic [3:0]     CONF = 4'(CONFIRM_FRAMES);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_HELD} state_t;

  state_t        state;
  logic          data_rdy_q;
  logic [TW-1:0] timer;
  logic [3:0]    match_cnt;
  logic [11:0]   cand;

  logic frame_evt;
  logic accepted;

  assign frame_evt = data_rdy & ~data_rdy_q;
  assign accepted  = frame_evt & (!ADDR_FILTER || (data[11:7] == ADDRESS));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      data_rdy_q   <= 1'b1;  // a level already high at reset exit is not a new frame
      timer        <= '0;
      match_cnt    <= '0;
      cand         <= '0;
      cmd          <= '0;
      addr         <= '0;
      press        <= 1'b0;
      held         <= 1'b0;
      key_release  <= 1'b0;
      repeat_count <= '0;
    end else begin
      data_rdy_q  <= data_rdy;
      press       <= 1'b0;
      key_release <= 1'b0;

      // Rejected frames leave the timer running so a foreign remote cannot keep a key alive.
      if (accepted)
        timer <= '0;
      else if (timer != TMAX)
        timer <= timer + TW'(1);

      case (state)
        S_IDLE: begin
          if (accepted) begin
            cand      <= data;
            match_cnt <= 4'd1;
            state     <= S_PENDING;
          end
        end

        S_PENDING: begin
          if (match_cnt >= CONF) begin
            state        <= S_HELD;
            press        <= 1'b1;
            held         <= 1'b1;
            cmd          <= cand[6:0];
            addr         <= cand[11:7];
            repeat_count <= '0;
          end else if (accepted) begin
            if (data == cand) begin
              match_cnt <= match_cnt + 4'd1;
            end else begin
              cand      <= data;
              match_cnt <= 4'd1;
            end
          end else if (timer == TMAX) begin
            state <= S_IDLE;
          end
        end

        S_HELD: begin
          if (accepted && (data == {addr, cmd})) begin
            if (repeat_count != 8'hFF)
              repeat_count <= repeat_count + 8'd1;
          end else if (accepted) begin
            key_release <= 1'b1;
            held        <= 1'b0;
            cand        <= data;
            match_cnt   <= 4'd1;
            state       <= S_PENDING;
          end else if (timer == TMAX) begin
            key_release <= 1'b1;
            held        <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
